// File: rtl/flag_handshake_pkg.sv
// flag_handshake_pkg: shared types and default constants for flag_handshake_tx.
package flag_handshake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PEND_W         = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Bits needed for a down-counter holding values 0..n-1 (never less than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flag_handshake_tx_if.sv
// flag_handshake_tx_if: event request, toggle handshake and status signals of
// the flag transmitter. master = transmitter, slave = requester / far side.
interface flag_handshake_tx_if
  import flag_handshake_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
);
  logic              req_clkA;
  logic              ack_async;
  logic              flag_clkA;
  logic              busy_clkA;
  logic              done_clkA;
  logic              overflow_clkA;
  logic [PEND_W-1:0] pending_clkA;
  logic              timeout_clkA;

  modport master (
    input  req_clkA, ack_async,
    output flag_clkA, busy_clkA, done_clkA, overflow_clkA, pending_clkA, timeout_clkA
  );

  modport slave (
    output req_clkA, ack_async,
    input  flag_clkA, busy_clkA, done_clkA, overflow_clkA, pending_clkA, timeout_clkA
  );
endinterface

// File: rtl/flag_handshake_tx_ack_sync.sv
// ack_sync_chain: plain flop chain bringing the far-domain ack level into clkA.
module ack_sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sync_q;

  // Shift the asynchronous level through DEPTH flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[DEPTH-2:0], d_i};
  end

  assign q_o = sync_q[DEPTH-1];
endmodule

// File: rtl/flag_handshake_tx.sv
// flag_handshake_tx: sends one flag toggle per event and waits for the far
// domain to echo it on ack_async. Requests arriving while a toggle is in
// flight are counted in pending_clkA and issued later, one per handshake.
// Build option: define FLAG_HANDSHAKE_TIMEOUT_EN to abandon a handshake after
// TIMEOUT_CYCLES clkA cycles without an ack.
//
// state    | meaning
// IDLE     | nothing outstanding; issue on fresh req or pending count
// WAIT_ACK | toggle sent, waiting for synchronized ack to equal flag
// GAP      | one-cycle spacer, keeps each flag level for >= 2 cycles
module flag_handshake_tx
  import flag_handshake_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PEND_W         = DEF_PEND_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                 clkA,
  input logic                 rstA_n,
  flag_handshake_tx_if.master hs
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic              flag_q, flag_d;
  logic              done_q, done_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              pend_inc, pend_dec;
  logic              ack_s;

`ifdef FLAG_HANDSHAKE_TIMEOUT_EN
  localparam int              TO_W    = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_q, to_d;
`endif

  ack_sync_chain #(
    .DEPTH(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i  (clkA),
    .rst_n_i(rstA_n),
    .d_i    (hs.ack_async),
    .q_o    (ack_s)
  );

  // Anything arriving while not in IDLE has to wait; a req in IDLE is always issued at once.
  assign pend_inc = hs.req_clkA && (state_q != ST_IDLE);

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    flag_d   = flag_q;
    done_d   = 1'b0;
    pend_dec = 1'b0;
`ifdef FLAG_HANDSHAKE_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    to_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hs.req_clkA || (pend_q != '0)) begin
          flag_d   = ~flag_q;
          state_d  = ST_WAIT_ACK;
          pend_dec = ~hs.req_clkA;
`ifdef FLAG_HANDSHAKE_TIMEOUT_EN
          to_cnt_d = TO_LOAD;
`endif
        end
      end
      ST_WAIT_ACK: begin
        if (ack_s == flag_q) begin
          done_d  = 1'b1;
          state_d = ST_GAP;
        end
`ifdef FLAG_HANDSHAKE_TIMEOUT_EN
        else if (to_cnt_q == '0) begin
          to_d    = 1'b1;
          state_d = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
`endif
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending counter: saturates, a request that finds it full is dropped.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (pend_inc && !pend_dec) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // FSM state, flag level and done pulse registers.
  always_ff @(posedge clkA or negedge rstA_n) begin
    if (!rstA_n) begin
      state_q <= ST_IDLE;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  // Pending count and overflow pulse registers.
  always_ff @(posedge clkA or negedge rstA_n) begin
    if (!rstA_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef FLAG_HANDSHAKE_TIMEOUT_EN
  // Ack timeout down-counter and its pulse.
  always_ff @(posedge clkA or negedge rstA_n) begin
    if (!rstA_n) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
    end
  end

  assign hs.timeout_clkA = to_q;
`else
  // No timeout logic: TIMEOUT_CYCLES is always positive, so this folds to 0.
  assign hs.timeout_clkA = (TIMEOUT_CYCLES < 0);
`endif

  assign hs.flag_clkA     = flag_q;
  assign hs.done_clkA     = done_q;
  assign hs.overflow_clkA = ovf_q;
  assign hs.pending_clkA  = pend_q;
  assign hs.busy_clkA     = (state_q != ST_IDLE) || (pend_q != '0);
endmodule
